branch_trace_buf: RTL
=====================

Name: branch_trace_buf

Overview:
Parametrised on-chip branch trace unit for the core's EX stage. Snoops resolved branches (PC, target, taken) and buffers them in a FIFO with a configurable overflow policy. Keeps saturating branch/taken/drop statistics and supports PC-triggered capture with a post-trigger window. Read out by a debug/UART path, so the trace survives long runs without depending on the testbench.

Parameters:
XLEN, 32, PC/target width
DEPTH, 16, FIFO entries; power of two, >=2
CNT_W, 32, statistics counter width
WRAP, 0, 0 = drop new events when full; 1 = overwrite oldest
POST_CNT, 8, events captured after trigger before auto-stop; 0 = unlimited

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse: arm (trig_en=1) or run (trig_en=0)
stop  in  1  pulse: force DONE
clear  in  1  pulse: flush FIFO, zero counters, go IDLE
trig_en  in  1  use PC trigger; sampled on start
trig_pc  in  XLEN  trigger PC
ex_is_branch  in  1  branch instruction in EX this cycle
ex_take_branch  in  1  branch resolved taken
ex_pc  in  XLEN  PC of EX branch
ex_target  in  XLEN  computed target
rd_en  in  1  pop request
rd_valid  out  1  rd_data valid (one cycle after accepted pop)
rd_data  out  2*XLEN+1  {taken, pc, target}
level  out  $clog2(DEPTH)+1  occupancy
empty  out  1  level==0
full  out  1  level==DEPTH
br_cnt  out  CNT_W  branches seen while capturing
taken_cnt  out  CNT_W  of those, taken
drop_cnt  out  CNT_W  events lost to overflow
state_o  out  2  IDLE=0, ARMED=1, RUN=2, DONE=3

Behaviour:
- Reset (rst=1 at edge): state IDLE; pointers, level, all counters 0; rd_valid=0; rd_data=0; empty=1, full=0.
- Control priority per cycle: rst > clear > stop > start. clear acts like reset, but only while rst=0.
- IDLE --start & trig_en--> ARMED; IDLE --start & !trig_en--> RUN. start is ignored in ARMED and RUN. From DONE, start re-arms or re-runs without flushing the FIFO.
- ARMED: a branch with ex_pc==trig_pc is captured in the same cycle and moves the state to RUN. The post-trigger counter is loaded to 0 and the trigger event is not counted against POST_CNT. Other branches in ARMED are ignored and not counted.
- RUN: every ex_is_branch is a capture event. br_cnt+1; taken_cnt+1 if ex_take_branch.
  - POST_CNT!=0 and the entry came in through ARMED: go to DONE in the cycle the POST_CNT-th post-trigger event is captured.
  - RUN entered without a trigger: POST_CNT is ignored.
- stop from any non-IDLE state goes to DONE. A branch in the same cycle as stop is not captured.
- Capture latency: an event at edge N is visible in level at N+1.
- Pop: accepted when rd_en & !empty. rd_data is registered; rd_valid=1 for exactly the next cycle. rd_en when empty is ignored, rd_valid=0. Popping is allowed in every state.
- Full, WRAP=0, no simultaneous pop: event dropped, drop_cnt+1; br_cnt and taken_cnt still update.
- Full, WRAP=1, no simultaneous pop: oldest entry overwritten, read pointer advances, level stays DEPTH, drop_cnt+1.
- Simultaneous push and pop: both happen, level unchanged, no drop (including when full). Pop returns the old head.
- Pointers wrap modulo DEPTH.
- All counters saturate at 2^CNT_W-1, no wrap.
- Reset or clear mid-pop cancels the pending rd_valid.

Decomposition:
- Shared package (trace_pkg): state encoding constants, entry field offsets (TAKEN_BIT, PC_LSB, TGT_LSB), entry width function.
- One natural sub-module: trace_fifo. Parametrised synchronous FIFO with WRAP overwrite, level/full/empty and registered read. The top holds the FSM, trigger compare and counters.

Test Plan:
- Reset then start with trig_en=0, 3 branches (pc 0x100/0x104/0x108, taken 1/0/1). Expect level=3, br_cnt=3, taken_cnt=2. Pops return {1,0x100,tgt},{0,0x104,tgt},{1,0x108,tgt}, each with rd_valid one cycle after rd_en.
- WRAP=0, DEPTH=4, 6 branches. Expect level=4, drop_cnt=2, full=1, and the pops return the first 4 events.
- WRAP=1, DEPTH=4, 6 branches. Expect level=4, drop_cnt=2, and the pops return events 3..6.
- trig_en=1, trig_pc=0x200, POST_CNT=2, branch stream 0x1F0,0x200,0x204,0x208,0x20C. Expect ARMED until 0x200, then capture of 0x200,0x204,0x208, DONE after 0x208, and level=3, br_cnt=3.
- Full FIFO with push and pop in the same cycle. Expect level stays 4, drop_cnt unchanged, and the old head popped.
- clear asserted together with a branch and an rd_en. Next cycle: state IDLE, level=0, all counters 0, rd_valid=0.

Source files
------------

// File: rtl/branch_trace_buf_pkg.sv
// Shared state encoding and trace-entry layout for the branch trace buffer.
// An entry is {taken, pc, target}, with target in the low bits.
package branch_trace_buf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int TGT_LSB = 0;

   function automatic int entry_w(input int xlen);
      return 2 * xlen + 1;
   endfunction

   function automatic int taken_bit(input int xlen);
      return 2 * xlen;
   endfunction

   function automatic int pc_lsb(input int xlen);
      return xlen;
   endfunction

endpackage

// File: rtl/branch_trace_buf_if.sv
// Bundle of EX-stage snoop signals and the debug read-out port.
// The master drives branches and pops; the slave is the trace buffer.
interface branch_trace_buf_if #(
   parameter int XLEN = 32
) ();
   logic              ex_is_branch;
   logic              ex_take_branch;
   logic [XLEN-1:0]   ex_pc;
   logic [XLEN-1:0]   ex_target;
   logic              rd_en;
   logic              rd_valid;
   logic [2*XLEN:0]   rd_data;

   modport master (
      output ex_is_branch, ex_take_branch, ex_pc, ex_target, rd_en,
      input  rd_valid, rd_data
   );

   modport slave (
      input  ex_is_branch, ex_take_branch, ex_pc, ex_target, rd_en,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/branch_trace_buf_fifo.sv
// Synchronous FIFO with optional overwrite-oldest on overflow and registered read.
// o_drop flags a push that met a full FIFO without a simultaneous pop.
module branch_trace_buf_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 16,
   parameter int WRAP  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic                     o_rd_valid,
   output logic [W-1:0]             o_rd_data,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_empty,
   output logic                     o_full,
   output logic                     o_drop
);
   localparam int         AW       = $clog2(DEPTH);
   localparam logic       WRAP_EN  = (WRAP != 0);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_level;
   logic          r_rd_valid;
   logic [W-1:0]  r_rd_data;
   logic          w_pop;
   logic          w_push;
   logic          w_ovw;

   assign o_level    = r_level;
   assign o_empty    = (r_level == '0);
   assign o_full     = (r_level == FULL_LVL);
   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;

   always_comb begin
      w_pop  = i_pop & ~o_empty;
      w_push = i_push & (~o_full | w_pop | WRAP_EN);
      w_ovw  = i_push & o_full & ~w_pop & WRAP_EN;
      o_drop = i_push & o_full & ~w_pop;
   end

   // Storage array needs no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_level    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= w_pop;
         if (w_pop) r_rd_data <= r_mem[r_rp];
         if (w_push) r_wp <= r_wp + AW'(1);
         // Overwrite drags the head forward so level stays at DEPTH.
         if (w_pop || w_ovw) r_rp <= r_rp + AW'(1);
         if (w_push && !w_pop && !w_ovw) r_level <= r_level + (AW + 1)'(1);
         else if (w_pop && !w_push) r_level <= r_level - (AW + 1)'(1);
      end
   end
endmodule

// File: rtl/branch_trace_buf.sv
// Branch trace unit: capture FSM with PC trigger and post-trigger window,
// saturating statistics, and a trace FIFO drained through the read port.
module branch_trace_buf
   import branch_trace_buf_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 16,
   parameter int CNT_W    = 32,
   parameter int WRAP     = 0,
   parameter int POST_CNT = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic                     i_stop,
   input  logic                     i_clear,
   input  logic                     i_trig_en,
   input  logic [XLEN-1:0]          i_trig_pc,
   branch_trace_buf_if.slave        bus,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [CNT_W-1:0]         o_br_cnt,
   output logic [CNT_W-1:0]         o_taken_cnt,
   output logic [CNT_W-1:0]         o_drop_cnt,
   output logic [1:0]               o_state
);
   localparam int          EW        = entry_w(XLEN);
   localparam int          TAKEN_BIT = taken_bit(XLEN);
   localparam int          PC_LSB    = pc_lsb(XLEN);
   localparam int          PW        = (POST_CNT < 1) ? 1 : $clog2(POST_CNT + 1);
   localparam logic        POST_EN   = (POST_CNT != 0);
   localparam logic [PW-1:0] POST_LIM = PW'(POST_CNT);
   localparam logic [CNT_W-1:0] CMAX  = '1;

   state_t            r_state;
   state_t            w_state_nx;
   logic [PW-1:0]     r_post;
   logic [PW-1:0]     w_post_nx;
   logic [PW-1:0]     w_post_inc;
   logic              r_trig;
   logic              w_trig_nx;
   logic              w_capture;
   logic              w_hit;
   logic              w_stop_eff;
   logic              w_drop;
   logic [EW-1:0]     w_entry;
   logic              w_rd_valid;
   logic [EW-1:0]     w_rd_data;
   logic [CNT_W-1:0]  r_br_cnt;
   logic [CNT_W-1:0]  r_taken_cnt;
   logic [CNT_W-1:0]  r_drop_cnt;

   assign o_state     = r_state;
   assign o_br_cnt    = r_br_cnt;
   assign o_taken_cnt = r_taken_cnt;
   assign o_drop_cnt  = r_drop_cnt;
   assign bus.rd_valid = w_rd_valid;
   assign bus.rd_data  = w_rd_data;

   always_comb begin
      w_entry                    = '0;
      w_entry[TAKEN_BIT]         = bus.ex_take_branch;
      w_entry[PC_LSB +: XLEN]    = bus.ex_pc;
      w_entry[TGT_LSB +: XLEN]   = bus.ex_target;
   end

   // Next-state, post-trigger window and capture decision.
   always_comb begin
      w_state_nx = r_state;
      w_post_nx  = r_post;
      w_trig_nx  = r_trig;
      w_capture  = 1'b0;
      w_post_inc = r_post + PW'(1);
      w_stop_eff = i_stop & (r_state != ST_IDLE);
      w_hit      = bus.ex_is_branch & (bus.ex_pc == i_trig_pc);
      if (i_clear) begin
         w_state_nx = ST_IDLE;
         w_post_nx  = '0;
         w_trig_nx  = 1'b0;
      end else if (w_stop_eff) begin
         w_state_nx = ST_DONE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  w_state_nx = i_trig_en ? ST_ARMED : ST_RUN;
                  w_trig_nx  = i_trig_en;
                  w_post_nx  = '0;
               end else begin
                  w_state_nx = r_state;
               end
            end
            ST_ARMED: begin
               if (w_hit) begin
                  w_capture  = 1'b1;
                  w_state_nx = ST_RUN;
                  w_post_nx  = '0;
               end else begin
                  w_state_nx = ST_ARMED;
               end
            end
            ST_RUN: begin
               if (bus.ex_is_branch) begin
                  w_capture = 1'b1;
                  // The window only applies after a real trigger.
                  if (r_trig && POST_EN) begin
                     w_post_nx = w_post_inc;
                     if (w_post_inc == POST_LIM) w_state_nx = ST_DONE;
                     else w_state_nx = ST_RUN;
                  end else begin
                     w_post_nx = r_post;
                  end
               end else begin
                  w_state_nx = ST_RUN;
               end
            end
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_post  <= '0;
         r_trig  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_post  <= w_post_nx;
         r_trig  <= w_trig_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_br_cnt    <= '0;
         r_taken_cnt <= '0;
         r_drop_cnt  <= '0;
      end else if (w_capture) begin
         if (r_br_cnt != CMAX) r_br_cnt <= r_br_cnt + CNT_W'(1);
         if (bus.ex_take_branch && r_taken_cnt != CMAX) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
         if (w_drop && r_drop_cnt != CMAX) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
   end

   branch_trace_buf_fifo #(
      .W     (EW),
      .DEPTH (DEPTH),
      .WRAP  (WRAP)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (i_clear),
      .i_push     (w_capture),
      .i_data     (w_entry),
      .i_pop      (bus.rd_en),
      .o_rd_valid (w_rd_valid),
      .o_rd_data  (w_rd_data),
      .o_level    (o_level),
      .o_empty    (o_empty),
      .o_full     (o_full),
      .o_drop     (w_drop)
   );
endmodule
